// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: issues PC fetches to imem, buffers in-order responses
// with their PCs and presents the head entry to decode over valid/ready.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  input  logic        id_ready,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [PW-1:0] tail_q, fill_q, head_q, drop_q;
  logic [PW-1:0] tail_n, fill_n, head_n, drop_n;
  logic [PW-1:0] count, unfilled;
  logic          pop, grant, do_fill, do_drop, rsp_bad;
  logic [AW-1:0] hd_idx;

  logic          vld_n, vld_p1;
  logic [31:0]   instr_n, instr_p1;
  logic [31:0]   pc_n, pc_p1;
  logic [31:0]   pc8_n, pc8_p1;
  logic          perr_q;

  function automatic logic [31:0] pc_plus8(input logic [31:0] a);
    return a + 32'd8;
  endfunction

  // Stage p0: request/grant and response classification
  assign count     = tail_q - head_q;
  assign unfilled  = tail_q - fill_q;
  assign pop       = vld_p1 && id_ready && !flush;
  assign imem_req  = !reset && !flush && ((count < PW'(DEPTH)) || pop);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign pc_en     = grant;

  assign do_drop   = imem_rvalid && (drop_q != '0);
  assign do_fill   = imem_rvalid && (drop_q == '0) && (unfilled != '0);
  assign rsp_bad   = imem_rvalid && (drop_q == '0) && (unfilled == '0);

  always_comb begin
    tail_n = tail_q + PW'(grant);
    fill_n = fill_q + PW'(do_fill);
    head_n = head_q + PW'(pop);
    drop_n = drop_q - PW'(do_drop);
    if (flush) begin
      tail_n = '0;
      fill_n = '0;
      head_n = '0;
      // Pending drops accumulate so a flush inside a drop window keeps count of old responses
      drop_n = drop_q + unfilled - PW'(do_drop | do_fill);
    end
    hd_idx  = head_n[AW-1:0];
    vld_n   = !flush && (fill_n != head_n);
    instr_n = (do_fill && (fill_q[AW-1:0] == hd_idx)) ? imem_rdata : instr_mem[hd_idx];
    pc_n    = pc_mem[hd_idx];
    pc8_n   = pc_plus8(pc_mem[hd_idx]);
  end

  always_ff @(posedge clk) begin
    if (grant) pc_mem[tail_q[AW-1:0]] <= pc;
    if (do_fill && !flush) instr_mem[fill_q[AW-1:0]] <= imem_rdata;
  end

  // Stage p1: registered head entry toward decode
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q   <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      perr_q   <= 1'b0;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      pc8_p1   <= '0;
    end else begin
      tail_q   <= tail_n;
      fill_q   <= fill_n;
      head_q   <= head_n;
      drop_q   <= drop_n;
      perr_q   <= perr_q | rsp_bad;
      vld_p1   <= vld_n;
      instr_p1 <= instr_n;
      pc_p1    <= pc_n;
      pc8_p1   <= pc8_n;
    end
  end

  assign id_valid  = vld_p1;
  assign id_instr  = instr_p1;
  assign id_pc     = pc_p1;
  assign id_pc8    = pc8_p1;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: PC register and in-order memory models with a
// scoreboard of granted PCs checked against what decode receives.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] pc, imem_rdata;
  logic        pc_en, imem_req, id_valid, proto_err;
  logic [31:0] imem_addr, id_instr, id_pc, id_pc8;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8), .id_ready(id_ready),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          npop     = 0;
  int          ngrant   = 0;
  logic        spur     = 1'b0;
  logic [31:0] flush_pc = 32'h3100;
  logic [31:0] last_pop_pc = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: observe the cycle's handshakes, advance, then drive PC and memory response
  task automatic tick();
    logic g, p, r, f;
    logic [31:0] hp;
    #1;
    g = pc_en;
    r = reset;
    f = flush;
    p = id_valid && id_ready && !flush && !reset;
    check("pc_en_vs_req_gnt", pc_en, imem_req & imem_gnt);
    check("imem_addr", imem_addr, pc);
    if (p) begin
      npop++;
      last_pop_pc = id_pc;
      if (sb.size() == 0) check("unexpected_id_valid", id_valid, 0);
      else begin
        hp = sb.pop_front();
        check("id_pc", id_pc, hp);
        check("id_instr", id_instr, memf(hp));
        check("id_pc8", id_pc8, hp + 32'd8);
      end
    end
    if (g) begin
      ngrant++;
      sb.push_back(pc);
      mq.push_back('{memf(pc), cyc + lat});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      pc = 32'h3000;
      mq.delete();
      sb.delete();
    end else if (f) begin
      pc = flush_pc;
      sb.delete();
    end else if (g) pc = pc + 32'd4;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hdeadbeef;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].data;
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0; spur = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    imem_gnt = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() > 0 || mq.size() > 0); i++) tick();
    check("drained", sb.size(), 0);
  endtask

  initial begin
    pc = 32'h3000; reset = 1'b1; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    tick();
    tick();

    // Reset state
    imem_gnt = 1'b1;
    #1;
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_pc8", id_pc8, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_addr", imem_addr, 32'h3000);

    // Streaming
    reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("stream_pc_en", pc_en, 1);
      check("stream_valid", id_valid, (i >= 2) ? 1 : 0);
      if (i == 2) check("first_pc8", id_pc8, 32'h3008);
      tick();
    end
    drain();

    // Backpressure
    do_reset();
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b0; ngrant = 0;
    repeat (8) tick();
    #1;
    check("bp_grants", ngrant, 4);
    check("bp_req_low", imem_req, 0);
    check("bp_pc_en_low", pc_en, 0);
    check("bp_pc_hold", pc, 32'h3010);
    id_ready = 1'b1;
    #1;
    check("bp_req_on_pop", imem_req, 1);
    tick();
    drain();

    // Memory stall
    do_reset();
    imem_gnt = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, 32'h3000);
      check("stall_pc_en", pc_en, 0);
      tick();
    end
    imem_gnt = 1'b1;
    #1;
    check("stall_grant", pc_en, 1);
    tick();
    imem_gnt = 1'b0;
    #1;
    check("stall_pulse_once", pc_en, 0);
    check("stall_addr_next", imem_addr, 32'h3004);
    drain();

    // Flush with three fetches in flight
    do_reset();
    lat = 4; imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (3) tick();
    imem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; imem_gnt = 1'b1;
    #1;
    check("flush_valid_low", id_valid, 0);
    check("flush_redirect_addr", imem_addr, 32'h3100);
    tick();
    imem_gnt = 1'b0; npop = 0;
    for (int i = 0; i < 20 && (sb.size() > 0 || mq.size() > 0); i++) tick();
    check("flush_done", sb.size(), 0);
    check("flush_one_pop", npop, 1);
    check("flush_last_pc", last_pop_pc, 32'h3100);
    check("flush_no_proto", proto_err, 0);

    // Protocol error
    do_reset();
    lat = 1; imem_gnt = 1'b0; id_ready = 1'b1;
    #1;
    check("perr_init", proto_err, 0);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    #1;
    check("perr_same_cycle", proto_err, 0);
    tick();
    #1;
    check("perr_set", proto_err, 1);
    imem_gnt = 1'b1;
    repeat (6) tick();
    #1;
    check("perr_sticky", proto_err, 1);
    drain();
    do_reset();
    #1;
    check("perr_cleared", proto_err, 0);

    // Reset mid-stream with two entries buffered
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
    repeat (2) tick();
    imem_gnt = 1'b0;
    repeat (2) tick();
    #1;
    check("mid_buffered", id_valid, 1);
    reset = 1'b1; imem_gnt = 1'b1;
    #1;
    check("mid_req_low", imem_req, 0);
    check("mid_pc_en_low", pc_en, 0);
    tick();
    #1;
    check("mid_valid_low", id_valid, 0);
    check("mid_req_low2", imem_req, 0);
    reset = 1'b0; id_ready = 1'b1; npop = 0;
    for (int i = 0; i < 10 && npop == 0; i++) tick();
    check("mid_popped", npop, 1);
    check("mid_first_pc", last_pop_pc, 32'h3000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch front end that consumes the PC register's output and drives its `EN` back-pressure. Each cycle it issues the current PC to instruction memory over a request/grant, in-order-response handshake and raises `pc_en` when the fetch is accepted. It then buffers returned instructions with their PCs in a DEPTH-entry in-order queue and presents them to the IF/ID stage with a valid/ready handshake. Flush on redirect discards everything in flight.

## Interface
- DEPTH, 4, queue entries and maximum outstanding fetches; power of two, >= 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc  in  32  current PC from the PC register
- pc_en  out  1  PC register enable; high exactly on cycles where imem_req && imem_gnt
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; equals pc (combinational)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
- imem_rdata  in  32  instruction word
- flush  in  1  redirect; discard all queued and in-flight fetches
- id_valid  out  1  head entry valid
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_pc8  out  32  head PC + 8 (mod 2^32)
- id_ready  in  1  decode accepts head this cycle
- proto_err  out  1  sticky: rvalid with no fetch outstanding

## Operation
- Queue entry: {pc, instr, filled}. Pointers: alloc (tail), fill, head; count = allocated entries (filled or not).
- Allocate: on imem_req && imem_gnt, write pc at tail, filled=0, tail++.
- imem_req = !reset && !flush && (count < DEPTH || pop this cycle).
- Fill: on imem_rvalid with drop_cnt==0 and an unfilled entry, write imem_rdata at fill pointer, set filled, fill++.
- Pop: on id_valid && id_ready, head++, count--.
- Allocate and pop in the same cycle are allowed at full; count is unchanged.
- id_valid/id_instr/id_pc/id_pc8 are registered from the head entry. id_valid = head filled.
- Flush:
  - Clear the queue and pointers.
  - drop_cnt <= (allocated-unfilled entries) minus 1 if imem_rvalid this cycle.
  - No allocate, fill or pop takes effect. id_valid = 0 next cycle.
- Drop: while drop_cnt > 0, each imem_rvalid decrements drop_cnt and its data is discarded. New fetches may be granted during the drop window. Their responses fill only after drop_cnt reaches 0; in-order return guarantees this.
- imem_rvalid with no unfilled entry and drop_cnt==0: ignored, proto_err <= 1 until reset.
- The PC alignment is not checked. Exception handling happens downstream.
- drop_cnt width: log2(DEPTH)+1 bits.

## Timing
- Reset (synchronous) value of all outputs and state: 0 (queue empty, drop_cnt 0, proto_err 0). imem_req=0 and pc_en=0 while reset is high; imem_addr still follows pc.
- Fetch latency: grant at cycle N, rvalid at N+k (k>=1), id_valid high at N+k+1.
- Throughput: one instruction per cycle with gnt=1, k=1, id_ready=1.
- While imem_gnt=0: imem_req stays high, imem_addr = pc (stable, since pc_en=0).
- Full (count==DEPTH, no pop): imem_req=0, pc_en=0.
- With full and pop in the same cycle: request allowed.
- Flush has priority over every other event in the same cycle, including id_ready pop and grant.
- Reset mid-operation:
  - In-flight responses after reset are not dropped. The system also resets memory.
  - rvalid in the first cycle after reset sets proto_err.

## Test plan
- Streaming:
  - Stimulus: after reset, pc steps 0x3000, 0x3004, ... on pc_en; gnt=1, k=1, id_ready=1.
  - Required: pc_en high every cycle; id_pc sequence 0x3000, 0x3004, ...; id_pc8 = 0x3008 for the first instruction; one id_valid per cycle starting 2 cycles after the first grant.
- Backpressure:
  - Stimulus: id_ready=0 with gnt=1.
  - Required: exactly DEPTH (4) grants, then imem_req=0 and pc_en=0; pc holds.
  - On id_ready=1: entries pop in order, and imem_req reasserts in the same cycle as the first pop.
- Memory stall:
  - Stimulus: imem_gnt=0 for 5 cycles.
  - Required: imem_req=1, imem_addr constant 0x3000, pc_en=0 throughout; grant on cycle 6 pulses pc_en once.
- Flush with in-flight fetches:
  - Stimulus: 3 fetches granted and unreturned; flush=1; pc=0x3100 next cycle.
  - Required: the next 3 rvalids are discarded; id_valid stays 0 until the 0x3100 instruction; id_pc=0x3100 with the correct instr.
- Protocol error:
  - Stimulus: rvalid with the queue empty and drop_cnt=0.
  - Required: proto_err rises next cycle, holds through further traffic, and clears only on reset.
- Reset mid-stream:
  - Stimulus: assert reset with 2 entries buffered.
  - Required: next cycle id_valid=0, imem_req=0, pc_en=0; normal fetch from 0x3000 after deassertion.
